// File: rtl/ddr_line_responder.sv
// Turns cache line read/write requests into single-beat commands on a MIG-style
// native app interface and returns a one-cycle fin pulse per request.
module ddr_line_responder #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] cache2DDR_rd_addr,
    input  logic              cache2DDR_rd_en,
    output logic              DDR2cache_rd_fin,
    output logic [DATA_W-1:0] DDR2cache_rd_data,
    input  logic [ADDR_W-1:0] cache2DDR_wr_addr,
    input  logic [DATA_W-1:0] cache2DDR_wr_data,
    input  logic              cache2DDR_wr_en,
    output logic              DDR2cache_wr_fin,
    input  logic              init_calib_complete,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_CMD  = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    // A 16-byte line maps to 8 consecutive 16-bit DRAM columns.
    function automatic logic [ADDR_W-1:0] line_to_col(input logic [ADDR_W-5:0] line_idx);
        return {1'b0, line_idx, 3'b000};
    endfunction

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   app_addr_r, app_addr_s;
    logic [2:0]          app_cmd_r, app_cmd_s;
    logic                app_en_r, app_en_s;
    logic [DATA_W-1:0]   wdf_data_r, wdf_data_s;
    logic                wdf_wren_r, wdf_wren_s;
    logic [DATA_W-1:0]   rd_data_r, rd_data_s;
    logic                rd_fin_r, rd_fin_s;
    logic                wr_fin_r, wr_fin_s;
    logic                cmd_done_r, cmd_done_s;
    logic                data_done_r, data_done_s;
    logic                rd_armed_r, rd_armed_s;
    logic                wr_armed_r, wr_armed_s;
    logic                fin_busy_s;
    logic                rd_elig_s;
    logic                wr_elig_s;
    logic                unused_s;

    assign unused_s   = ^{cache2DDR_rd_addr[3:0], cache2DDR_wr_addr[3:0]};
    assign fin_busy_s = rd_fin_r | wr_fin_r;
    assign rd_elig_s  = cache2DDR_rd_en & rd_armed_r & init_calib_complete & ~fin_busy_s;
    assign wr_elig_s  = cache2DDR_wr_en & wr_armed_r & init_calib_complete & ~fin_busy_s;

    // Next-state and next-output logic for the transaction FSM and arming flags.
    always_comb begin
        state_s     = state_r;
        app_addr_s  = app_addr_r;
        app_cmd_s   = app_cmd_r;
        app_en_s    = app_en_r;
        wdf_data_s  = wdf_data_r;
        wdf_wren_s  = wdf_wren_r;
        rd_data_s   = rd_data_r;
        rd_fin_s    = 1'b0;
        wr_fin_s    = 1'b0;
        cmd_done_s  = cmd_done_r;
        data_done_s = data_done_r;
        case (state_r)
            IDLE: begin
                // Write has priority so a coincident read observes the new line.
                if (wr_elig_s) begin
                    app_addr_s  = line_to_col(cache2DDR_wr_addr[ADDR_W-1:4]);
                    app_cmd_s   = CMD_WR;
                    app_en_s    = 1'b1;
                    wdf_data_s  = cache2DDR_wr_data;
                    wdf_wren_s  = 1'b1;
                    cmd_done_s  = 1'b0;
                    data_done_s = 1'b0;
                    state_s     = WR;
                end else if (rd_elig_s) begin
                    app_addr_s = line_to_col(cache2DDR_rd_addr[ADDR_W-1:4]);
                    app_cmd_s  = CMD_RD;
                    app_en_s   = 1'b1;
                    state_s    = RD_CMD;
                end else begin
                    state_s = IDLE;
                end
            end
            WR: begin
                cmd_done_s  = cmd_done_r | (app_en_r & app_rdy);
                data_done_s = data_done_r | (wdf_wren_r & app_wdf_rdy);
                app_en_s    = app_en_r & ~app_rdy;
                wdf_wren_s  = wdf_wren_r & ~app_wdf_rdy;
                if (cmd_done_s && data_done_s) begin
                    wr_fin_s    = 1'b1;
                    cmd_done_s  = 1'b0;
                    data_done_s = 1'b0;
                    state_s     = IDLE;
                end else begin
                    state_s = WR;
                end
            end
            RD_CMD: begin
                if (app_rdy) begin
                    app_en_s = 1'b0;
                    state_s  = RD_WAIT;
                end else begin
                    app_en_s = 1'b1;
                    state_s  = RD_CMD;
                end
            end
            RD_WAIT: begin
                if (app_rd_data_valid) begin
                    rd_data_s = app_rd_data;
                    rd_fin_s  = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            default: begin
                state_s    = IDLE;
                app_en_s   = 1'b0;
                wdf_wren_s = 1'b0;
            end
        endcase

        // A level request held past its fin is not re-served until it drops.
        if (!cache2DDR_rd_en) begin
            rd_armed_s = 1'b1;
        end else if (rd_fin_s) begin
            rd_armed_s = 1'b0;
        end else begin
            rd_armed_s = rd_armed_r;
        end
        if (!cache2DDR_wr_en) begin
            wr_armed_s = 1'b1;
        end else if (wr_fin_s) begin
            wr_armed_s = 1'b0;
        end else begin
            wr_armed_s = wr_armed_r;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= IDLE;
            app_addr_r  <= {ADDR_W{1'b0}};
            app_cmd_r   <= CMD_RD;
            app_en_r    <= 1'b0;
            wdf_data_r  <= {DATA_W{1'b0}};
            wdf_wren_r  <= 1'b0;
            rd_data_r   <= {DATA_W{1'b0}};
            rd_fin_r    <= 1'b0;
            wr_fin_r    <= 1'b0;
            cmd_done_r  <= 1'b0;
            data_done_r <= 1'b0;
            rd_armed_r  <= 1'b1;
            wr_armed_r  <= 1'b1;
        end else begin
            state_r     <= state_s;
            app_addr_r  <= app_addr_s;
            app_cmd_r   <= app_cmd_s;
            app_en_r    <= app_en_s;
            wdf_data_r  <= wdf_data_s;
            wdf_wren_r  <= wdf_wren_s;
            rd_data_r   <= rd_data_s;
            rd_fin_r    <= rd_fin_s;
            wr_fin_r    <= wr_fin_s;
            cmd_done_r  <= cmd_done_s;
            data_done_r <= data_done_s;
            rd_armed_r  <= rd_armed_s;
            wr_armed_r  <= wr_armed_s;
        end
    end

    assign app_addr          = app_addr_r;
    assign app_cmd           = app_cmd_r;
    assign app_en            = app_en_r;
    assign app_wdf_data      = wdf_data_r;
    assign app_wdf_wren      = wdf_wren_r;
    assign app_wdf_end       = wdf_wren_r;
    assign DDR2cache_rd_data = rd_data_r;
    assign DDR2cache_rd_fin  = rd_fin_r;
    assign DDR2cache_wr_fin  = wr_fin_r;

endmodule

// File: tb/tb_ddr_line_responder.sv
// Directed self-checking bench for ddr_line_responder; inputs driven and outputs
// sampled on the falling clock edge.
module tb_ddr_line_responder;

    logic         clk = 1'b0;
    logic         rstn;
    logic [26:0]  cache2DDR_rd_addr;
    logic         cache2DDR_rd_en;
    logic         DDR2cache_rd_fin;
    logic [127:0] DDR2cache_rd_data;
    logic [26:0]  cache2DDR_wr_addr;
    logic [127:0] cache2DDR_wr_data;
    logic         cache2DDR_wr_en;
    logic         DDR2cache_wr_fin;
    logic         init_calib_complete;
    logic [26:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;

    int n_checks = 0;
    int n_pass   = 0;
    int cmd_cnt  = 0;
    int wr_fin_cnt = 0;
    int rd_fin_cnt = 0;
    bit fin_double = 1'b0;
    logic prev_rd_fin = 1'b0;
    logic prev_wr_fin = 1'b0;

    localparam logic [127:0] DATA_A = 128'hDEAD0000_11112222_33334444_0000BEEF;
    localparam logic [127:0] DATA_B = 128'h55556666_77778888_9999AAAA_BBBBCCCC;
    localparam logic [127:0] WDATA  = 128'h01234567_89ABCDEF_01234567_89ABCDEF;

    always #5 clk = ~clk;

    ddr_line_responder dut (
        .clk                 (clk),
        .rstn                (rstn),
        .cache2DDR_rd_addr   (cache2DDR_rd_addr),
        .cache2DDR_rd_en     (cache2DDR_rd_en),
        .DDR2cache_rd_fin    (DDR2cache_rd_fin),
        .DDR2cache_rd_data   (DDR2cache_rd_data),
        .cache2DDR_wr_addr   (cache2DDR_wr_addr),
        .cache2DDR_wr_data   (cache2DDR_wr_data),
        .cache2DDR_wr_en     (cache2DDR_wr_en),
        .DDR2cache_wr_fin    (DDR2cache_wr_fin),
        .init_calib_complete (init_calib_complete),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid)
    );

    // Bus monitor: accepted commands, fin pulses, back-to-back fin detection.
    always @(posedge clk) begin
        if (rstn && app_en && app_rdy) cmd_cnt <= cmd_cnt + 1;
        if (DDR2cache_wr_fin) wr_fin_cnt <= wr_fin_cnt + 1;
        if (DDR2cache_rd_fin) rd_fin_cnt <= rd_fin_cnt + 1;
        if ((DDR2cache_rd_fin && prev_rd_fin) || (DDR2cache_wr_fin && prev_wr_fin)) fin_double <= 1'b1;
        prev_rd_fin <= DDR2cache_rd_fin;
        prev_wr_fin <= DDR2cache_wr_fin;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // Return read data after `gap` falling edges, then confirm the fin pulse and data.
    task automatic read_return(input int gap, input logic [127:0] data, input string tag);
        repeat (gap) @(negedge clk);
        app_rd_data_valid = 1'b1;
        app_rd_data       = data;
        @(negedge clk);
        app_rd_data_valid = 1'b0;
        check({tag, "_fin"}, 128'(DDR2cache_rd_fin), 128'(1'b1));
        check({tag, "_data"}, DDR2cache_rd_data, data);
    endtask

    initial begin
        bit seen;
        bit any_en;
        int base_cmd;
        int base_wr_fin;
        int base_rd_fin;

        rstn = 1'b0;
        cache2DDR_rd_addr = 27'h0; cache2DDR_rd_en = 1'b0;
        cache2DDR_wr_addr = 27'h0; cache2DDR_wr_data = 128'h0; cache2DDR_wr_en = 1'b0;
        init_calib_complete = 1'b1; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        app_rd_data = 128'h0; app_rd_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_app_en", 128'(app_en), 128'(1'b0));
        check("rst_app_cmd", 128'(app_cmd), 128'(3'b001));
        check("rst_wren", 128'({app_wdf_wren, app_wdf_end}), 128'(2'b00));
        check("rst_fins", 128'({DDR2cache_rd_fin, DDR2cache_wr_fin}), 128'(2'b00));
        check("rst_addr", 128'(app_addr), 128'(27'h0));
        check("rst_rd_data", DDR2cache_rd_data, 128'h0);
        rstn = 1'b1;

        // Basic read, held request
        @(negedge clk);
        cache2DDR_rd_addr = 27'h0001230; cache2DDR_rd_en = 1'b1; app_rdy = 1'b1;
        @(negedge clk);
        check("rd1_app_en", 128'(app_en), 128'(1'b1));
        check("rd1_app_cmd", 128'(app_cmd), 128'(3'b001));
        check("rd1_app_addr", 128'(app_addr), 128'(27'h0000918));
        read_return(5, DATA_A, "rd1");
        @(negedge clk);
        check("rd1_fin_single", 128'(DDR2cache_rd_fin), 128'(1'b0));
        base_cmd = cmd_cnt;
        repeat (6) @(negedge clk);
        check("rd1_no_reissue", 128'(cmd_cnt), 128'(base_cmd));
        check("rd1_no_reissue_en", 128'(app_en), 128'(1'b0));
        cache2DDR_rd_en = 1'b0;
        @(negedge clk);
        cache2DDR_rd_en = 1'b1;
        @(negedge clk);
        check("rd2_reissue_en", 128'(app_en), 128'(1'b1));
        read_return(1, DATA_B, "rd2");
        cache2DDR_rd_en = 1'b0;
        @(negedge clk);

        // Write with command handshake stalled three cycles
        app_rdy = 1'b0; app_wdf_rdy = 1'b1;
        cache2DDR_wr_addr = 27'h7FFFFF0; cache2DDR_wr_data = WDATA; cache2DDR_wr_en = 1'b1;
        @(negedge clk);
        cache2DDR_wr_en = 1'b0;
        check("wr1_app_en", 128'(app_en), 128'(1'b1));
        check("wr1_wren_end", 128'({app_wdf_wren, app_wdf_end}), 128'(2'b11));
        check("wr1_app_cmd", 128'(app_cmd), 128'(3'b000));
        check("wr1_app_addr", 128'(app_addr), 128'(27'h3FFFFF8));
        check("wr1_wdf_data", app_wdf_data, WDATA);
        @(negedge clk);
        check("wr1_wdf_taken", 128'({app_wdf_wren, app_wdf_end}), 128'(2'b00));
        check("wr1_cmd_pending", 128'(app_en), 128'(1'b1));
        @(negedge clk);
        check("wr1_no_early_fin", 128'(DDR2cache_wr_fin), 128'(1'b0));
        @(negedge clk);
        app_rdy = 1'b1;
        @(negedge clk);
        check("wr1_fin", 128'(DDR2cache_wr_fin), 128'(1'b1));
        check("wr1_en_dropped", 128'(app_en), 128'(1'b0));
        @(negedge clk);
        check("wr1_fin_single", 128'(DDR2cache_wr_fin), 128'(1'b0));

        // Simultaneous read and write
        cache2DDR_rd_addr = 27'h0000040; cache2DDR_wr_addr = 27'h0000080;
        cache2DDR_wr_data = DATA_B; cache2DDR_rd_en = 1'b1; cache2DDR_wr_en = 1'b1;
        base_wr_fin = wr_fin_cnt; base_rd_fin = rd_fin_cnt;
        @(negedge clk);
        check("sim_wr_first_cmd", 128'({app_en, app_cmd, app_wdf_wren}), 128'({1'b1, 3'b000, 1'b1}));
        check("sim_wr_addr", 128'(app_addr), 128'(27'h0000040));
        @(negedge clk);
        check("sim_wr_fin", 128'(DDR2cache_wr_fin), 128'(1'b1));
        check("sim_no_overlap", 128'(app_en), 128'(1'b0));
        cache2DDR_wr_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            seen = app_en && (app_cmd == 3'b001);
        end
        check("sim_rd_issued", 128'(seen), 128'(1'b1));
        check("sim_rd_addr", 128'(app_addr), 128'(27'h0000020));
        check("sim_order", 128'({wr_fin_cnt - base_wr_fin, rd_fin_cnt - base_rd_fin}), 128'({32'd1, 32'd0}));
        read_return(2, DATA_A, "sim_rd");
        cache2DDR_rd_en = 1'b0;
        @(negedge clk);

        // Calibration gating
        init_calib_complete = 1'b0;
        cache2DDR_rd_addr = 27'h0000100; cache2DDR_rd_en = 1'b1;
        any_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            any_en = any_en | app_en;
        end
        check("cal_held", 128'(any_en), 128'(1'b0));
        init_calib_complete = 1'b1;
        @(negedge clk);
        check("cal_issue", 128'(app_en), 128'(1'b1));
        check("cal_addr", 128'(app_addr), 128'(27'h0000080));
        @(negedge clk);

        // Reset while waiting for read data
        rstn = 1'b0; cache2DDR_rd_en = 1'b0;
        @(negedge clk);
        check("rstrd_en", 128'({app_en, app_wdf_wren, app_wdf_end}), 128'(3'b000));
        check("rstrd_fins", 128'({DDR2cache_rd_fin, DDR2cache_wr_fin}), 128'(2'b00));
        check("rstrd_cmd_addr", 128'({app_cmd, app_addr}), 128'({3'b001, 27'h0}));
        check("rstrd_rd_data", DDR2cache_rd_data, 128'h0);
        rstn = 1'b1;
        @(negedge clk);
        app_rd_data_valid = 1'b1; app_rd_data = DATA_B;
        @(negedge clk);
        app_rd_data_valid = 1'b0;
        seen = DDR2cache_rd_fin;
        repeat (2) begin
            @(negedge clk);
            seen = seen | DDR2cache_rd_fin;
        end
        check("rstrd_late_valid_ignored", 128'(seen), 128'(1'b0));
        check("rstrd_data_kept", DDR2cache_rd_data, 128'h0);

        // Back-to-back pulsed writes
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        base_cmd = cmd_cnt; base_wr_fin = wr_fin_cnt;
        cache2DDR_wr_addr = 27'h0000A50; cache2DDR_wr_data = DATA_A; cache2DDR_wr_en = 1'b1;
        @(negedge clk);
        cache2DDR_wr_en = 1'b0;
        check("b2b_a_addr", 128'({app_en, app_cmd, app_addr}), 128'({1'b1, 3'b000, 27'h0000528}));
        @(negedge clk);
        check("b2b_a_fin", 128'(DDR2cache_wr_fin), 128'(1'b1));
        @(negedge clk);
        check("b2b_fin_gap", 128'(DDR2cache_wr_fin), 128'(1'b0));
        cache2DDR_wr_addr = 27'h1234560; cache2DDR_wr_data = DATA_B; cache2DDR_wr_en = 1'b1;
        @(negedge clk);
        cache2DDR_wr_en = 1'b0;
        check("b2b_b_addr", 128'({app_en, app_cmd, app_addr}), 128'({1'b1, 3'b000, 27'h091A2B0}));
        check("b2b_b_data", app_wdf_data, DATA_B);
        @(negedge clk);
        check("b2b_b_fin", 128'(DDR2cache_wr_fin), 128'(1'b1));
        @(negedge clk);
        check("b2b_counts", 128'({cmd_cnt - base_cmd, wr_fin_cnt - base_wr_fin}), 128'({32'd2, 32'd2}));
        check("fin_never_double", 128'(fin_double), 128'(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ddr_line_responder.md
Name: ddr_line_responder

Overview:
- DDR-side responder for the cache's 128-bit line interface. It serves cache line-fill reads and line write-throughs.
- Each cache request is turned into one command on a MIG-style native app interface (16-bit DRAM, 128-bit user data). The block returns a one-cycle fin pulse to the cache.
- It sits between the cache block and the DDR controller IP. Exactly one transaction is outstanding at any time.

Parameters:
- ADDR_W, 27, width of the cache byte address and of app_addr
- DATA_W, 128, line and app data width; only 128 is supported

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- cache2DDR_rd_addr  in  27  byte address of the line to read; bits [3:0] are ignored
- cache2DDR_rd_en  in  1  read request; level, may stay high after fin
- DDR2cache_rd_fin  out  1  one-cycle pulse; read data valid
- DDR2cache_rd_data  out  128  line read from DDR
- cache2DDR_wr_addr  in  27  byte address of the line to write; bits [3:0] are ignored
- cache2DDR_wr_data  in  128  line to write
- cache2DDR_wr_en  in  1  write request; level
- DDR2cache_wr_fin  out  1  one-cycle pulse; write accepted by the controller
- init_calib_complete  in  1  DDR controller ready
- app_addr  out  27  controller address
- app_cmd  out  3  3'b000 = write, 3'b001 = read
- app_en  out  1  command valid
- app_rdy  in  1  command accepted when app_en && app_rdy
- app_wdf_data  out  128  write data
- app_wdf_wren  out  1  write data valid
- app_wdf_end  out  1  equals app_wdf_wren; single-beat burst
- app_wdf_rdy  in  1  data accepted when app_wdf_wren && app_wdf_rdy
- app_rd_data  in  128  read return data
- app_rd_data_valid  in  1  read return strobe

Behaviour:
- Reset: rstn, synchronous, active-low; clock clk. While rstn = 0:
  - All outputs are 0 and app_cmd = 3'b001.
  - state = IDLE; rd_armed = wr_armed = 1.
- Reset mid-transaction aborts the transaction: no fin is issued, and app_en / app_wdf_wren drop on the next edge.
- Address mapping: app_addr = {1'b0, addr[26:4], 3'b000}. This converts a 16-byte line to 8 x 16-bit DRAM columns.
- Arming (handles an enable held high):
  - rd_armed clears when DDR2cache_rd_fin is pulsed and sets again on any cycle with cache2DDR_rd_en = 0. wr_armed behaves the same with the write signals.
  - A request is eligible only if en && armed.
- State IDLE, when init_calib_complete = 1:
  - Eligible write: latch addr and data; assert app_en, app_cmd = 000, app_wdf_wren, app_wdf_end; go to WR.
  - Else eligible read: latch addr; assert app_en, app_cmd = 001; go to RD_CMD.
  - If both are eligible in the same cycle, the write wins. The read stays pending and is taken after the write finishes, so the read observes the written line.
  - With init_calib_complete = 0, requests are held and nothing is issued.
- State WR:
  - Command and data are accepted independently. cmd_done is set on the app_en && app_rdy edge, which drops app_en. data_done is set on the app_wdf_wren && app_wdf_rdy edge, which drops app_wdf_wren and app_wdf_end.
  - Both handshakes may complete in the same cycle or in either order.
  - When both are complete (including the accepting edge), pulse DDR2cache_wr_fin on the next cycle and return to IDLE.
  - Minimum latency from request to wr_fin is 2 cycles.
- State RD_CMD: hold app_en until app_rdy, then drop app_en and go to RD_WAIT.
- State RD_WAIT:
  - On app_rd_data_valid, register DDR2cache_rd_data <= app_rd_data, pulse DDR2cache_rd_fin for one cycle, and go to IDLE.
  - DDR2cache_rd_data holds its value until the next read return.
  - Minimum latency from request to rd_fin is 3 cycles.
  - app_rd_data_valid seen in any state other than RD_WAIT is ignored.
- No timeout; a wait lasts as long as the controller stalls.
- A new request can be accepted no earlier than the cycle after fin.
- Fin outputs are registered and never high for two consecutive cycles.

Test Plan:
- Basic read: rd_addr = 27'h0001230, rd_en held high. Controller returns 128'hDEAD..BEEF 5 cycles after accepting the command. Required: app_addr = 27'h0000918, app_cmd = 001, one rd_fin pulse with rd_data = 128'hDEAD..BEEF. No second read is issued while rd_en stays high; a new read is issued only after rd_en goes low and then high again.
- Write with skewed handshakes: wr_addr = 27'h7FFFFF0, wr_data = 128'h0123..CDEF. app_rdy is held low 3 cycles while app_wdf_rdy = 1 immediately. Required: wdf beat accepted first, command accepted 3 cycles later, app_addr = 27'h3FFFFF8, exactly one wr_fin pulse after both handshakes.
- Simultaneous requests: rd_en and wr_en rise in the same cycle. Required: write command and data issued first, wr_fin, then read command issued, then rd_fin; no overlap between the two.
- Calibration gating: init_calib_complete = 0 with rd_en = 1 for 10 cycles. Required: app_en stays 0. After calibration rises, the read is issued within 1 cycle.
- Reset mid-read: assert rstn = 0 in RD_WAIT. Required: all outputs are 0 after the edge. A late app_rd_data_valid after reset is released produces no rd_fin.
- Back-to-back writes: pulse wr_en (1 cycle) for line A, then again for line B the cycle after wr_fin. Required: two distinct commands with the correct addresses, and two separated wr_fin pulses.
